// File: rtl/bcd_gray_arbiter_if.sv
// Request/result bus for bcd_gray_arbiter.
// Two BCD requesters (valid/bcd/ready each) and one result channel
// (valid/gray/id/err with consumer ready).
//   master : drives requests and out_ready, observes readys and result
//   slave  : the arbiter side
interface bcd_gray_arbiter_if;
    localparam int unsigned DIGIT_W = 4;

    logic               req0_valid;
    logic [DIGIT_W-1:0] req0_bcd;
    logic               req0_ready;
    logic               req1_valid;
    logic [DIGIT_W-1:0] req1_bcd;
    logic               req1_ready;
    logic               out_valid;
    logic [DIGIT_W-1:0] out_gray;
    logic               out_id;
    logic               out_err;
    logic               out_ready;

    modport master (
        output req0_valid, req0_bcd, req1_valid, req1_bcd, out_ready,
        input  req0_ready, req1_ready, out_valid, out_gray, out_id, out_err
    );

    modport slave (
        input  req0_valid, req0_bcd, req1_valid, req1_bcd, out_ready,
        output req0_ready, req1_ready, out_valid, out_gray, out_id, out_err
    );
endinterface

// File: rtl/bcd_gray_arbiter.sv
// Two-requester arbiter feeding one shared BCD-to-Gray converter with a
// single-entry output register.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : bcd_gray_arbiter_if.slave (requests, readys, result)
//   conv_count : results consumed, saturating at 255
//   err_count  : consumed results flagged invalid BCD, saturating at 255
// RR_EN = 1 selects round-robin on ties, 0 gives requester 0 fixed priority.
// reqN_ready is combinational from valids, state, out_ready and pointer.
module bcd_gray_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    bcd_gray_arbiter_if.slave         bus,
    output logic [7:0]                conv_count,
    output logic [7:0]                err_count
);
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(255);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last_grant;
    logic [DIGIT_W-1:0]   r_out_gray;
    logic                 r_out_id;
    logic                 r_out_err;
    logic [CNT_W-1:0]     r_conv_count;
    logic [CNT_W-1:0]     r_err_count;

    logic                 w_accept_en;
    logic                 w_tie_winner;
    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_xfer;
    logic                 w_consume;
    logic [DIGIT_W-1:0]   w_digit;
    logic                 w_bcd_err;
    logic [DIGIT_W-1:0]   w_gray;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, shared converter and next-state
    always_comb begin
        w_state_nxt  = r_state;
        w_accept_en  = 1'b0;
        w_tie_winner = 1'b0;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_xfer       = 1'b0;
        w_consume    = 1'b0;
        w_digit      = '0;
        w_bcd_err    = 1'b0;
        w_gray       = '0;

        // rst gates the accept so readys stay low during reset
        w_accept_en = !rst && ((r_state == ST_IDLE) || bus.out_ready);
        w_consume   = (r_state == ST_FULL) && bus.out_ready;

        // Round-robin favours whoever was not granted last
        w_tie_winner = RR_EN ? !r_last_grant : 1'b0;

        w_grant0 = w_accept_en && bus.req0_valid &&
                   (!bus.req1_valid || (w_tie_winner == 1'b0));
        w_grant1 = w_accept_en && bus.req1_valid &&
                   (!bus.req0_valid || (w_tie_winner == 1'b1));
        w_xfer   = w_grant0 || w_grant1;

        w_digit   = w_grant1 ? bus.req1_bcd : bus.req0_bcd;
        w_bcd_err = (w_digit > DIGIT_W'(9));
        if (!w_bcd_err) begin
            w_gray = {w_digit[3],
                      w_digit[2] | w_digit[3],
                      w_digit[2] ^ w_digit[1],
                      w_digit[1] ^ w_digit[0]};
        end

        if (w_xfer) begin
            w_state_nxt = ST_FULL;
        end else if (w_consume) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Result register and grant pointer, loaded only on an accepted transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_gray   <= '0;
            r_out_id     <= 1'b0;
            r_out_err    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_out_gray   <= w_gray;
            r_out_id     <= w_grant1;
            r_out_err    <= w_bcd_err;
            r_last_grant <= w_grant1;
        end
    end

    // Saturating consumption counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conv_count <= '0;
            r_err_count  <= '0;
        end else if (w_consume) begin
            if (r_conv_count != CNT_MAX) begin
                r_conv_count <= r_conv_count + CNT_W'(1);
            end
            if (r_out_err && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.out_valid  = (r_state == ST_FULL);
    assign bus.out_gray   = r_out_gray;
    assign bus.out_id     = r_out_id;
    assign bus.out_err    = r_out_err;
    assign conv_count     = r_conv_count;
    assign err_count      = r_err_count;

endmodule

// File: tb/tb_bcd_gray_arbiter.sv
// Directed self-checking bench for bcd_gray_arbiter.
// dut_rr runs round-robin; dut_fp runs fixed priority and shares clk/rst.
module tb_bcd_gray_arbiter;
    bit clk = 1'b0;
    logic rst;
    logic [7:0] rr_conv, rr_err, fp_conv, fp_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    bcd_gray_arbiter_if bus_rr ();
    bcd_gray_arbiter_if bus_fp ();

    bcd_gray_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_rr),
        .conv_count (rr_conv),
        .err_count  (rr_err)
    );

    bcd_gray_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_fp),
        .conv_count (fp_conv),
        .err_count  (fp_err)
    );

    always #5 clk = ~clk;

    logic [3:0] gray_tab [0:9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                   4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus_rr.req0_valid = 1'b0; bus_rr.req0_bcd = '0;
        bus_rr.req1_valid = 1'b0; bus_rr.req1_bcd = '0;
        bus_rr.out_ready  = 1'b0;
        bus_fp.req0_valid = 1'b0; bus_fp.req0_bcd = '0;
        bus_fp.req1_valid = 1'b0; bus_fp.req1_bcd = '0;
        bus_fp.out_ready  = 1'b1;

        // Reset state, and readys held low while rst is high
        tick(); tick();
        bus_rr.req0_valid = 1'b1;
        bus_rr.req1_valid = 1'b1;
        bus_rr.out_ready  = 1'b1;
        #1;
        chk("rst_ready0", 32'(bus_rr.req0_ready), 32'd0);
        chk("rst_ready1", 32'(bus_rr.req1_ready), 32'd0);
        chk("rst_valid",  32'(bus_rr.out_valid), 32'd0);
        chk("rst_gray",   32'(bus_rr.out_gray), 32'd0);
        chk("rst_id",     32'(bus_rr.out_id), 32'd0);
        chk("rst_err",    32'(bus_rr.out_err), 32'd0);
        chk("rst_conv",   32'(rr_conv), 32'd0);
        chk("rst_errcnt", 32'(rr_err), 32'd0);
        bus_rr.req0_valid = 1'b0;
        bus_rr.req1_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Sweep digits 0-9 back to back from requester 0
        for (int d = 0; d < 10; d++) begin
            bus_rr.req0_valid = 1'b1;
            bus_rr.req0_bcd   = 4'(d);
            #1;
            chk("sweep_ready0", 32'(bus_rr.req0_ready), 32'd1);
            tick();
            chk("sweep_valid", 32'(bus_rr.out_valid), 32'd1);
            chk("sweep_gray",  32'(bus_rr.out_gray), 32'(gray_tab[d]));
            chk("sweep_id",    32'(bus_rr.out_id), 32'd0);
        end
        bus_rr.req0_valid = 1'b0;
        tick();
        chk("sweep_conv",  32'(rr_conv), 32'd10);
        chk("sweep_empty", 32'(bus_rr.out_valid), 32'd0);

        // Invalid digits from requester 1
        bus_rr.req1_valid = 1'b1;
        bus_rr.req1_bcd   = 4'd10;
        tick();
        chk("inv10_err",  32'(bus_rr.out_err), 32'd1);
        chk("inv10_gray", 32'(bus_rr.out_gray), 32'd0);
        chk("inv10_id",   32'(bus_rr.out_id), 32'd1);
        bus_rr.req1_bcd = 4'd15;
        tick();
        chk("inv15_err",  32'(bus_rr.out_err), 32'd1);
        chk("inv15_gray", 32'(bus_rr.out_gray), 32'd0);
        chk("inv15_id",   32'(bus_rr.out_id), 32'd1);
        bus_rr.req1_valid = 1'b0;
        tick();
        chk("inv_errcnt", 32'(rr_err), 32'd2);
        chk("inv_conv",   32'(rr_conv), 32'd12);

        // Ties after reset: RR alternates starting at 0, FP always 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_rr.req0_valid = 1'b1; bus_rr.req0_bcd = 4'd1;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_bcd = 4'd2;
        bus_fp.req0_valid = 1'b1; bus_fp.req0_bcd = 4'd1;
        bus_fp.req1_valid = 1'b1; bus_fp.req1_bcd = 4'd2;
        #1;
        chk("tie_rr_ready0", 32'(bus_rr.req0_ready), 32'd1);
        chk("tie_rr_ready1", 32'(bus_rr.req1_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tie_rr_id", 32'(bus_rr.out_id), 32'(i % 2));
            chk("tie_fp_id", 32'(bus_fp.out_id), 32'd0);
            chk("tie_fp_ready1", 32'(bus_fp.req1_ready), 32'd0);
        end
        bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0;
        bus_fp.req0_valid = 1'b0; bus_fp.req1_valid = 1'b0;
        tick();
        chk("tie_rr_conv", 32'(rr_conv), 32'd4);
        chk("tie_fp_conv", 32'(fp_conv), 32'd4);

        // Backpressure on a result for digit 7
        bus_rr.req0_valid = 1'b1; bus_rr.req0_bcd = 4'd7;
        bus_rr.out_ready  = 1'b0;
        tick();
        bus_rr.req0_bcd   = 4'd5;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_bcd = 4'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready0", 32'(bus_rr.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus_rr.req1_ready), 32'd0);
            chk("bp_gray",   32'(bus_rr.out_gray), 32'b0100);
            chk("bp_valid",  32'(bus_rr.out_valid), 32'd1);
            chk("bp_conv",   32'(rr_conv), 32'd4);
            tick();
        end
        bus_rr.req0_valid = 1'b0;
        bus_rr.out_ready  = 1'b1;
        #1;
        chk("bp_rel_ready1", 32'(bus_rr.req1_ready), 32'd1);
        tick();
        chk("bp_rel_gray",  32'(bus_rr.out_gray), 32'b0010);
        chk("bp_rel_id",    32'(bus_rr.out_id), 32'd1);
        chk("bp_rel_valid", 32'(bus_rr.out_valid), 32'd1);
        chk("bp_rel_conv",  32'(rr_conv), 32'd5);
        bus_rr.req1_valid = 1'b0;
        tick();
        chk("bp_drain_conv",  32'(rr_conv), 32'd6);
        chk("bp_drain_valid", 32'(bus_rr.out_valid), 32'd0);

        // Reset while FULL with out_ready high; pointer left at 0 beforehand
        bus_rr.req0_valid = 1'b1; bus_rr.req0_bcd = 4'd1;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready0", 32'(bus_rr.req0_ready), 32'd0);
        tick();
        chk("mid_rst_valid", 32'(bus_rr.out_valid), 32'd0);
        chk("mid_rst_conv",  32'(rr_conv), 32'd0);
        rst = 1'b0;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_bcd = 4'd2;
        #1;
        chk("mid_tie_ready0", 32'(bus_rr.req0_ready), 32'd1);
        chk("mid_tie_ready1", 32'(bus_rr.req1_ready), 32'd0);
        tick();
        chk("mid_tie_id", 32'(bus_rr.out_id), 32'd0);
        bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0;
        tick();

        // Saturation: 260 consumed invalid-digit results
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_bcd = 4'd11;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k == 255) begin
                chk("sat_conv_254", 32'(rr_conv), 32'd254);
            end
        end
        bus_rr.req1_valid = 1'b0;
        tick();
        chk("sat_conv", 32'(rr_conv), 32'd255);
        chk("sat_err",  32'(rr_err), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
